// File: rtl/sem_mem_return_connector.sv
// ---------------------------------------------------------------------------
// sem_mem_return_connector
//
// Return-path mailbox between two semaphore instances. Semaphore B produces
// words over a valid/ready handshake. Semaphore A drains them through a
// has-data/read poll interface. Words are buffered in a DEPTH-entry circular
// FIFO, so B is only stalled when every slot is occupied.
//
// Parameters
//   DEPTH  FIFO entries (>= 2, need not be a power of two)
//   WIDTH  payload bits per word
//
// Ports
//   clk_s                in   single clock, rising edge
//   rst_s                in   synchronous active-high reset
//   sema_valid_o_s_B     in   B offers a word this cycle
//   sema_data_o_s_B      in   B payload, sampled only on accept
//   sema_ready_i_s_B     out  connector can accept (FIFO not full)
//   sema_has_data_i_s_A  out  at least one word stored for A
//   sema_data_i_s_A      out  head-of-FIFO word (show-ahead)
//   sema_read_o_s_A      in   A pops the head word this cycle
//   sema_level_s         out  number of stored words
//   sema_underflow_s     out  sticky: A read while the FIFO was empty
// ---------------------------------------------------------------------------
module sem_mem_return_connector #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                           clk_s,
  input  logic                           rst_s,
  input  logic                           sema_valid_o_s_B,
  input  logic [WIDTH-1:0]               sema_data_o_s_B,
  output logic                           sema_ready_i_s_B,
  output logic                           sema_has_data_i_s_A,
  output logic [WIDTH-1:0]               sema_data_i_s_A,
  input  logic                           sema_read_o_s_A,
  output logic [$clog2(DEPTH+1)-1:0]     sema_level_s,
  output logic                           sema_underflow_s
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             underflow_q, underflow_d;

  logic push;
  logic pop;

  // Outputs decode registered state only, so there is no valid->ready path
  // and no combinational B->A bypass.
  assign sema_ready_i_s_B    = (count_q != FULL_CNT);
  assign sema_has_data_i_s_A = (count_q != '0);
  assign sema_data_i_s_A     = mem_q[rd_ptr_q];
  assign sema_level_s        = count_q;
  assign sema_underflow_s    = underflow_q;

  assign push = sema_valid_o_s_B & sema_ready_i_s_B;
  assign pop  = sema_read_o_s_A  & sema_has_data_i_s_A;

  // Pointers wrap by explicit compare because DEPTH need not be 2^n.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);

    // Push and pop together leave the occupancy unchanged.
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // A read against an empty FIFO is flagged even if a push lands this cycle.
    if (sema_read_o_s_A && !sema_has_data_i_s_A) underflow_d = 1'b1;
  end

  always_ff @(posedge clk_s) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_s) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      // NOTE: storage is cleared too, so the show-ahead data output reads 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      if (push) mem_q[wr_ptr_q] <= sema_data_o_s_B;
    end
  end

endmodule

// File: tb/tb_sem_mem_return_connector.sv
module tb_sem_mem_return_connector;

  logic clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // DEPTH=4 instance
  logic       rst4, valid4, read4;
  logic [0:0] din4, dout4;
  logic       ready4, hasd4, und4;
  logic [2:0] lvl4;

  // DEPTH=3 instance
  logic       rst3, valid3, read3;
  logic [0:0] din3, dout3;
  logic       ready3, hasd3, und3;
  logic [1:0] lvl3;

  sem_mem_return_connector #(.DEPTH(4), .WIDTH(1)) u4 (
    .clk_s(clk_s), .rst_s(rst4),
    .sema_valid_o_s_B(valid4), .sema_data_o_s_B(din4), .sema_ready_i_s_B(ready4),
    .sema_has_data_i_s_A(hasd4), .sema_data_i_s_A(dout4), .sema_read_o_s_A(read4),
    .sema_level_s(lvl4), .sema_underflow_s(und4)
  );

  sem_mem_return_connector #(.DEPTH(3), .WIDTH(1)) u3 (
    .clk_s(clk_s), .rst_s(rst3),
    .sema_valid_o_s_B(valid3), .sema_data_o_s_B(din3), .sema_ready_i_s_B(ready3),
    .sema_has_data_i_s_A(hasd3), .sema_data_i_s_A(dout3), .sema_read_o_s_A(read3),
    .sema_level_s(lvl3), .sema_underflow_s(und3)
  );

  int total = 0;
  int bad   = 0;

  logic q4 [$];
  logic q3 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one active edge, then settle just past it.
  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  // Monitors: a pop happens on the next edge whenever read & has_data,
  // so the head word is compared against the scoreboard on the falling edge.
  always @(negedge clk_s) begin
    if (!rst4 && read4 && hasd4) begin
      if (q4.size() == 0) check("d4_unexpected_pop", 32'(dout4), 32'hx);
      else check("d4_data", 32'(dout4), 32'(q4.pop_front()));
    end
  end

  always @(negedge clk_s) begin
    if (!rst3 && read3 && hasd3) begin
      if (q3.size() == 0) check("d3_unexpected_pop", 32'(dout3), 32'hx);
      else check("d3_data", 32'(dout3), 32'(q3.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push4(input logic d);
    valid4 = 1'b1; din4 = d; q4.push_back(d);
    step();
    valid4 = 1'b0;
  endtask

  initial begin
    logic [6:0] seq3;
    seq3 = 7'b1011001; // sent LSB first: 1,0,0,1,1,0,1

    rst4 = 1'b1; valid4 = 1'b1; din4 = 1'b1; read4 = 1'b0;
    rst3 = 1'b1; valid3 = 1'b0; din3 = 1'b0; read3 = 1'b0;

    // 1: reset with a word offered for two cycles
    step(); step();
    rst4 = 1'b0; valid4 = 1'b0; din4 = 1'b0;
    rst3 = 1'b0;
    check("rst_ready", 32'(ready4), 32'd1);
    check("rst_has_data", 32'(hasd4), 32'd0);
    check("rst_level", 32'(lvl4), 32'd0);
    check("rst_underflow", 32'(und4), 32'd0);
    check("rst_data", 32'(dout4), 32'd0);
    step();
    check("rst_nothing_stored", 32'(lvl4), 32'd0);

    // 2: single word
    push4(1'b1);
    check("single_has_data", 32'(hasd4), 32'd1);
    check("single_level", 32'(lvl4), 32'd1);
    check("single_data", 32'(dout4), 32'd1);
    read4 = 1'b1; step(); read4 = 1'b0;
    check("single_drained_has_data", 32'(hasd4), 32'd0);
    check("single_drained_level", 32'(lvl4), 32'd0);

    // 3: fill, hold a fifth word while full, then drain in order
    push4(1'b1); push4(1'b0); push4(1'b1); push4(1'b1);
    check("full_level", 32'(lvl4), 32'd4);
    check("full_ready", 32'(ready4), 32'd0);
    valid4 = 1'b1; din4 = 1'b0; q4.push_back(1'b0);
    step();
    check("full_held_level", 32'(lvl4), 32'd4);
    check("full_held_ready", 32'(ready4), 32'd0);
    read4 = 1'b1; step(); read4 = 1'b0;
    check("pop_from_full_level", 32'(lvl4), 32'd3);
    check("pop_from_full_ready", 32'(ready4), 32'd1);
    step();
    valid4 = 1'b0;
    check("held_word_taken_level", 32'(lvl4), 32'd4);
    read4 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    read4 = 1'b0;
    check("fill_drained_level", 32'(lvl4), 32'd0);
    check("fill_no_underflow", 32'(und4), 32'd0);

    // 5: underflow is sticky, normal traffic continues
    read4 = 1'b1; step(); read4 = 1'b0;
    check("uf_flag", 32'(und4), 32'd1);
    check("uf_level", 32'(lvl4), 32'd0);
    push4(1'b0);
    check("uf_push_level", 32'(lvl4), 32'd1);
    read4 = 1'b1; step(); read4 = 1'b0;
    check("uf_pop_level", 32'(lvl4), 32'd0);
    check("uf_still_set", 32'(und4), 32'd1);
    // push and read together while empty: word stored, read is an underflow
    valid4 = 1'b1; din4 = 1'b1; read4 = 1'b1; q4.push_back(1'b1);
    step();
    valid4 = 1'b0; read4 = 1'b0;
    check("empty_push_read_level", 32'(lvl4), 32'd1);
    check("empty_push_read_data", 32'(dout4), 32'd1);
    // one entry with push+pop: count stays 1, new word shown
    valid4 = 1'b1; din4 = 1'b0; read4 = 1'b1; q4.push_back(1'b0);
    step();
    valid4 = 1'b0; read4 = 1'b0;
    check("one_entry_pushpop_level", 32'(lvl4), 32'd1);
    check("one_entry_pushpop_data", 32'(dout4), 32'd0);
    read4 = 1'b1; step(); read4 = 1'b0;
    check("one_entry_drained", 32'(lvl4), 32'd0);

    // 6: reset mid-operation discards stored words
    push4(1'b1); push4(1'b0); push4(1'b1);
    check("pre_rst_level", 32'(lvl4), 32'd3);
    rst4 = 1'b1; valid4 = 1'b1; din4 = 1'b1; read4 = 1'b1;
    step();
    q4.delete();
    rst4 = 1'b0; valid4 = 1'b0; read4 = 1'b0;
    check("mid_rst_level", 32'(lvl4), 32'd0);
    check("mid_rst_has_data", 32'(hasd4), 32'd0);
    check("mid_rst_underflow", 32'(und4), 32'd0);
    push4(1'b0); push4(1'b1);
    read4 = 1'b1; step(); step(); read4 = 1'b0;
    check("post_rst_level", 32'(lvl4), 32'd0);

    // 4: DEPTH=3 streaming, pointers wrap twice
    valid3 = 1'b1; din3 = seq3[0]; q3.push_back(seq3[0]); step();
    din3 = seq3[1]; q3.push_back(seq3[1]); step();
    check("wrap_prefill_level", 32'(lvl3), 32'd2);
    read3 = 1'b1;
    for (int i = 2; i < 7; i++) begin
      din3 = seq3[i]; q3.push_back(seq3[i]);
      step();
      check("wrap_stream_level", 32'(lvl3), 32'd2);
    end
    valid3 = 1'b0;
    step(); step();
    read3 = 1'b0;
    check("wrap_drained_level", 32'(lvl3), 32'd0);
    check("wrap_no_underflow", 32'(und3), 32'd0);

    step();
    check("sb4_empty", 32'(q4.size()), 32'd0);
    check("sb3_empty", 32'(q3.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
